// File: rtl/candy_avb_pio_bitbang_master_pkg.sv
// Shared types and constants for the Avalon PIO bit-bang master and its bit timer.
// Bus addresses follow the PIO slave register map: data latch and direction.
package candy_avb_pio_bitbang_master_pkg;

  localparam int unsigned LEN_W      = 5;
  localparam int unsigned AVB_ADDR_W = 2;
  localparam int unsigned AVB_DATA_W = 32;

  localparam logic [AVB_ADDR_W-1:0] PIO_DATA = AVB_ADDR_W'(0);
  localparam logic [AVB_ADDR_W-1:0] PIO_DIR  = AVB_ADDR_W'(1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT_DIR,
    ST_INIT_DATA,
    ST_DRIVE,
    ST_WAIT,
    ST_SAMPLE,
    ST_CAPTURE,
    ST_RELEASE,
    ST_DONE
  } state_e;

  // One Avalon-MM master beat towards the PIO slave
  typedef struct packed {
    logic                  chipselect;
    logic                  write_n;
    logic [AVB_ADDR_W-1:0] address;
    logic [AVB_DATA_W-1:0] writedata;
  } avb_cmd_t;

  // Counter width able to hold BIT_CYCLES-1 (the per-bit wait reload value)
  function automatic int unsigned bit_cycles_width(input int unsigned cycles);
    return (cycles <= 1) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/candy_avb_bit_timer.sv
// Loadable down-counter; done_c is high whenever the count has reached zero.
// Holds at zero until reloaded, so it can idle between bits.
module candy_avb_bit_timer #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done_c
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (count_q != '0) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign done_c = (count_q == '0);

endmodule

// File: rtl/candy_avb_pio_bitbang_master.sv
// Avalon-MM master that bit-bangs a word onto an open-drain line through a one-bit
// PIO slave (reg 0 = data latch / pin, reg 1 = direction) and returns the sampled word.
module candy_avb_pio_bitbang_master
  import candy_avb_pio_bitbang_master_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 4,
  parameter int unsigned MAX_BITS   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [MAX_BITS-1:0]   cmd_data,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic                  cmd_read,
  output logic                  rsp_valid,
  output logic [MAX_BITS-1:0]   rsp_data,
  output logic [AVB_ADDR_W-1:0] address,
  output logic                  chipselect,
  output logic                  write_n,
  output logic [AVB_DATA_W-1:0] writedata,
  input  logic [AVB_DATA_W-1:0] readdata
);

  localparam int unsigned TMR_W = bit_cycles_width(BIT_CYCLES);
  localparam int unsigned IDX_W = (MAX_BITS <= 1) ? 1 : $clog2(MAX_BITS);
  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_BITS);
  localparam logic [TMR_W-1:0] WAIT_LOAD = TMR_W'(BIT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [MAX_BITS-1:0]   data_q, data_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic                  read_q, read_d;
  logic [MAX_BITS-1:0]   shift_q, shift_d;
  logic                  timer_load_c;
  logic                  timer_done_c;
  logic                  drive_low_c;
  avb_cmd_t              bus_d;
  logic                  readdata_unused_c;

  assign readdata_unused_c = ^readdata[AVB_DATA_W-1:1];

  candy_avb_bit_timer #(
    .WIDTH (TMR_W)
  ) u_bit_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (timer_load_c),
    .load_value (WAIT_LOAD),
    .done_c     (timer_done_c)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, datapath updates and the bus beat for the upcoming state
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    read_d       = read_q;
    shift_d      = shift_q;
    timer_load_c = 1'b0;
    drive_low_c  = 1'b0;
    bus_d        = '{chipselect: 1'b0, write_n: 1'b1, address: PIO_DATA, writedata: '0};

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          data_d  = cmd_data;
          cnt_d   = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
          read_d  = cmd_read;
          shift_d = '0;
          state_d = ST_INIT_DIR;
        end
      end
      ST_INIT_DIR:  state_d = ST_INIT_DATA;
      ST_INIT_DATA: state_d = (cnt_q == '0) ? ST_RELEASE : ST_DRIVE;
      ST_DRIVE: begin
        timer_load_c = 1'b1;
        state_d      = ST_WAIT;
      end
      ST_WAIT: begin
        if (timer_done_c) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        shift_d = {shift_q[MAX_BITS-2:0], readdata[0]};
        cnt_d   = cnt_q - LEN_W'(1);
        state_d = (cnt_d == '0) ? ST_RELEASE : ST_DRIVE;
      end
      ST_RELEASE: state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    // Outputs are registered, so decode the beat from the state being entered
    drive_low_c = ~read_d & ~data_d[IDX_W'(cnt_d - LEN_W'(1))];

    case (state_d)
      ST_INIT_DIR: begin
        bus_d.chipselect = 1'b1;
        bus_d.write_n    = 1'b0;
        bus_d.address    = PIO_DIR;
      end
      ST_INIT_DATA: begin
        bus_d.chipselect = 1'b1;
        bus_d.write_n    = 1'b0;
        bus_d.address    = PIO_DATA;
      end
      ST_DRIVE: begin
        bus_d.chipselect = 1'b1;
        bus_d.write_n    = 1'b0;
        bus_d.address    = PIO_DIR;
        bus_d.writedata  = AVB_DATA_W'(drive_low_c);
      end
      ST_SAMPLE: begin
        bus_d.chipselect = 1'b1;
      end
      ST_RELEASE: begin
        bus_d.chipselect = 1'b1;
        bus_d.write_n    = 1'b0;
        bus_d.address    = PIO_DIR;
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs; rsp_valid lands on the edge leaving DONE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= '0;
      cnt_q      <= '0;
      read_q     <= 1'b0;
      shift_q    <= '0;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      chipselect <= 1'b0;
      write_n    <= 1'b1;
      address    <= PIO_DATA;
      writedata  <= '0;
    end else begin
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      read_q     <= read_d;
      shift_q    <= shift_d;
      cmd_ready  <= (state_d == ST_IDLE);
      rsp_valid  <= (state_q == ST_DONE);
      if (state_q == ST_DONE) begin
        rsp_data <= shift_q;
      end
      chipselect <= bus_d.chipselect;
      write_n    <= bus_d.write_n;
      address    <= bus_d.address;
      writedata  <= bus_d.writedata;
    end
  end

endmodule

// File: tb/tb_candy_avb_pio_bitbang_master.sv
// Bench for candy_avb_pio_bitbang_master: PIO slave model with pull-up and an external
// pull-down device, table vectors, corner sequences and randomized commands.
module tb_candy_avb_pio_bitbang_master;

  localparam int unsigned B       = 4;
  localparam int unsigned MB      = 16;
  localparam int          BIT_LAT = B + 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [MB-1:0] cmd_data;
  logic [4:0]    cmd_len;
  logic          cmd_read;
  logic          rsp_valid;
  logic [MB-1:0] rsp_data;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;

  candy_avb_pio_bitbang_master #(
    .BIT_CYCLES (B),
    .MAX_BITS   (MB)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_data   (cmd_data),
    .cmd_len    (cmd_len),
    .cmd_read   (cmd_read),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  // PIO slave: data latch, direction register, registered pin readback
  logic          pio_dir;
  logic          pio_data;
  int            bit_no;
  logic [MB-1:0] ext_mask;
  int            bad_writes = 0;
  logic [33:0]   wlog[$];
  logic [33:0]   exp_q[$];
  logic          pin;

  always_comb begin
    pin = pio_dir ? pio_data : 1'b1;
    if (bit_no >= 1 && bit_no <= int'(MB)) begin
      if (ext_mask[bit_no-1]) pin = 1'b0;
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pio_dir  <= 1'b0;
      pio_data <= 1'b0;
      bit_no   <= 0;
      readdata <= '0;
    end else begin
      readdata <= {31'b0, pin};
      if (chipselect && !write_n) begin
        wlog.push_back({address, writedata});
        if (address == 2'd0) begin
          pio_data <= writedata[0];
          bit_no   <= 0;
        end else if (address == 2'd1) begin
          pio_dir <= writedata[0];
          bit_no  <= bit_no + 1;
        end
        if (address > 2'd1 || writedata[31:1] != 31'd0) bad_writes <= bad_writes + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Reference: expected bus writes, sampled word and latency from the line rules
  task automatic model(input logic [MB-1:0] d, input logic [4:0] len, input logic rd,
                       input logic [MB-1:0] mask, output logic [MB-1:0] rsp, output int lat);
    int   l;
    logic low;
    l = (int'(len) > int'(MB)) ? int'(MB) : int'(len);
    exp_q.delete();
    exp_q.push_back({2'd1, 32'd0});
    exp_q.push_back({2'd0, 32'd0});
    rsp = '0;
    for (int k = 0; k < l; k++) begin
      low = !rd && !d[l-1-k];
      exp_q.push_back({2'd1, 31'd0, low});
      rsp = {rsp[MB-2:0], (!low && !mask[k])};
    end
    exp_q.push_back({2'd1, 32'd0});
    lat = l * BIT_LAT + 4;
  endtask

  task automatic chk_writes(input string name);
    int diff = -1;
    n_tot++;
    for (int i = 0; i < exp_q.size() && i < wlog.size(); i++) begin
      if (diff < 0 && wlog[i] !== exp_q[i]) diff = i;
    end
    if (diff < 0 && wlog.size() != exp_q.size()) diff = (wlog.size() < exp_q.size()) ? wlog.size() : exp_q.size();
    if (diff >= 0)
      $display("FAIL %s writes: got %0d writes, expected %0d, first difference at write %0d", name, wlog.size(), exp_q.size(), diff);
    else
      n_pass++;
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (!cmd_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) begin
      n_tot++;
      $display("FAIL rsp_timeout: rsp_valid low after %0d cycles, expected a pulse", lat);
      lat = -1;
    end
  endtask

  task automatic run_cmd(input string name, input logic [MB-1:0] d, input logic [4:0] len,
                         input logic rd, input logic [MB-1:0] mask, input logic use_tab,
                         input logic [MB-1:0] tab_rsp, input int tab_lat);
    logic [MB-1:0] m_rsp;
    int            m_lat;
    int            lat;
    model(d, len, rd, mask, m_rsp, m_lat);
    if (use_tab) begin
      m_rsp = tab_rsp;
      m_lat = tab_lat;
    end
    ext_mask = mask;
    wlog.delete();
    cmd_data  = d;
    cmd_len   = len;
    cmd_read  = rd;
    cmd_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk({name, " busy"}, 32'(cmd_ready), 32'd0);
    wait_rsp(lat);
    chk({name, " latency"}, 32'(lat), 32'(m_lat));
    chk({name, " rsp_data"}, 32'(rsp_data), 32'(m_rsp));
    chk({name, " ready_at_rsp"}, 32'(cmd_ready), 32'd1);
    @(negedge clk);
    chk({name, " rsp_pulse"}, 32'(rsp_valid), 32'd0);
    chk_writes(name);
  endtask

  typedef struct {
    logic [MB-1:0] data;
    logic [4:0]    len;
    logic          rd;
    logic [MB-1:0] mask;
    logic [MB-1:0] exp_rsp;
    int            exp_lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int            lat;
    logic          ok;
    logic [MB-1:0] rd_data;
    logic [4:0]    rd_len;
    logic          rd_read;
    logic [MB-1:0] rd_mask;

    vecs[0] = '{16'h00A5, 5'd8,  1'b0, 16'h0000, 16'h00A5, 60};
    vecs[1] = '{16'h0000, 5'd4,  1'b1, 16'h000A, 16'h000A, 32};
    vecs[2] = '{16'h1234, 5'd0,  1'b0, 16'h0000, 16'h0000, 4};
    vecs[3] = '{16'hFFFF, 5'd20, 1'b0, 16'h0000, 16'hFFFF, 116};
    vecs[4] = '{16'h00F0, 5'd8,  1'b0, 16'h0001, 16'h0070, 60};
    vecs[5] = '{16'h1234, 5'd16, 1'b1, 16'h0000, 16'hFFFF, 116};
    vecs[6] = '{16'h8001, 5'd16, 1'b0, 16'h0000, 16'h8001, 116};
    vecs[7] = '{16'h0003, 5'd1,  1'b0, 16'h0000, 16'h0001, 11};

    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    cmd_len   = '0;
    cmd_read  = 1'b0;
    ext_mask  = '0;
    repeat (3) @(negedge clk);
    chk("reset ctrl {ready,rsp_valid,cs,write_n,addr}",
        32'({cmd_ready, rsp_valid, chipselect, write_n, address}), 32'h24);
    chk("reset writedata", writedata, 32'd0);
    chk("reset rsp_data", 32'(rsp_data), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset during the second bit's DRIVE beat aborts at once
    wlog.delete();
    cmd_data  = 16'h00A5;
    cmd_len   = 5'd8;
    cmd_read  = 1'b0;
    cmd_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid drive {cs,write_n,addr}", 32'({chipselect, write_n, address}), 32'h9);
    chk("mid drive writedata", writedata, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async reset ctrl {ready,rsp_valid,cs,write_n,addr}",
        32'({cmd_ready, rsp_valid, chipselect, write_n, address}), 32'h24);
    chk("async reset writedata", writedata, 32'd0);
    chk("async reset rsp_data", 32'(rsp_data), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("after reset ready", 32'(cmd_ready), 32'd1);
    chk("after reset idle bus", 32'({chipselect, write_n}), 32'h1);

    for (int i = 0; i < 8; i++) begin
      run_cmd($sformatf("vec%0d", i), vecs[i].data, vecs[i].len, vecs[i].rd, vecs[i].mask,
              1'b1, vecs[i].exp_rsp, vecs[i].exp_lat);
    end

    // cmd_valid held high across two commands
    wlog.delete();
    ext_mask  = '0;
    cmd_data  = 16'h0005;
    cmd_len   = 5'd3;
    cmd_read  = 1'b0;
    cmd_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    @(negedge clk);
    cmd_data = 16'h0002;
    cmd_len  = 5'd2;
    wait_rsp(lat);
    chk("b2b first latency", 32'(lat), 32'd25);
    chk("b2b first rsp_data", 32'(rsp_data), 32'h5);
    chk("b2b ready at rsp", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    chk("b2b second accepted", 32'(cmd_ready), 32'd0);
    ok = (wlog.size() == 6) && (wlog[5] == {2'd1, 32'd0});
    chk("b2b release write between commands", 32'(ok), 32'd1);
    cmd_valid = 1'b0;
    wait_rsp(lat);
    chk("b2b second latency", 32'(lat + 1), 32'd19);
    chk("b2b second rsp_data", 32'(rsp_data), 32'h2);
    @(negedge clk);
    chk("b2b rsp pulse", 32'(rsp_valid), 32'd0);

    for (int i = 0; i < 25; i++) begin
      rd_data = MB'($urandom);
      rd_len  = 5'($urandom_range(0, 20));
      rd_read = ($urandom_range(0, 3) == 0);
      rd_mask = MB'($urandom) & MB'($urandom);
      run_cmd($sformatf("rand%0d", i), rd_data, rd_len, rd_read, rd_mask, 1'b0, '0, 0);
    end

    chk("write address/data range", 32'(bad_writes), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
